// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues word fetches to instruction memory,
// buffers one fetched instruction for downstream, and handles redirects
// and halt. All buses are numbered with bit 0 as the MSB.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | request outstanding at reqPc; completion fills the buffer
// WAIT   | buffer holds a valid instruction until downstream accepts
// SQUASH | stale request still outstanding; its data will be dropped
// HALTED | no requests issued until halt drops or a redirect arrives
module fetch_sequencer #(
  parameter int                  PC_WIDTH = 30,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [0:31]         imem_addr,
  input  logic                imem_ack,
  input  logic [0:31]         imem_data,
  output logic                out_valid,
  output logic [0:31]         out_instr,
  output logic [0:31]         out_pc,
  input  logic                out_ready,
  input  logic                redir_valid,
  input  logic [0:PC_WIDTH-1] redir_target,
  input  logic                halt
);

  typedef enum logic [1:0] {FETCH, WAIT, SQUASH, HALTED} stateT;

  stateT               state, stateNext;
  logic [0:PC_WIDTH-1] pc, pcNext, pcInc;
  // Address of the request on the bus; kept apart from pc so a redirect
  // can retarget pc while the stale request is still being held.
  logic [0:PC_WIDTH-1] reqPc, reqPcNext;
  logic                validNext;
  logic [0:31]         instrNext, outPcNext;
  logic                reqOn, done;

  // Request is gated by reset so nothing is asked for while reset is held.
  assign reqOn     = ((state == FETCH) || (state == SQUASH)) && reset;
  assign done      = reqOn && imem_ack;
  assign pcInc     = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign imem_req  = reqOn;
  assign imem_addr = {reqPc, 2'b00};

  // State, pc and the output buffer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      reqPc     <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      reqPc     <= reqPcNext;
      out_valid <= validNext;
      out_instr <= instrNext;
      out_pc    <= outPcNext;
    end
  end

  // Next-state logic; a redirect takes priority in every state.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    validNext = out_valid;
    instrNext = out_instr;
    outPcNext = out_pc;
    case (state)
      FETCH: begin
        if (redir_valid) begin
          pcNext    = redir_target;
          stateNext = done ? FETCH : SQUASH;
        end else if (done) begin
          instrNext = imem_data;
          outPcNext = {pcInc, 2'b00};
          validNext = 1'b1;
          pcNext    = pcInc;
          stateNext = WAIT;
        end
      end
      SQUASH: begin
        if (redir_valid) begin
          pcNext    = redir_target;
          stateNext = done ? FETCH : SQUASH;
        end else if (done) begin
          stateNext = FETCH;
        end
      end
      WAIT: begin
        if (redir_valid) begin
          validNext = 1'b0;
          pcNext    = redir_target;
          stateNext = FETCH;
        end else if (out_ready) begin
          validNext = 1'b0;
          stateNext = halt ? HALTED : FETCH;
        end
      end
      HALTED: begin
        if (redir_valid) begin
          pcNext    = redir_target;
          stateNext = FETCH;
        end else if (!halt) begin
          stateNext = FETCH;
        end
      end
      default: stateNext = FETCH;
    endcase
    // A new request always starts from the pc we enter FETCH with.
    reqPcNext = (stateNext == FETCH) ? pcNext : reqPc;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 30, word-address width of PC.
REQ-002 SHALL have parameter RESET_PC, default 30'h0, word address loaded at reset.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clock  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have port imem_req  out  1  instruction memory request.
REQ-007 SHALL have port imem_addr  out  32 [0:31]  byte address {pc,2'b00}.
REQ-008 SHALL have port imem_ack  in  1  data valid; completes request.
REQ-009 SHALL have port imem_data  in  32 [0:31]  instruction word.
REQ-010 SHALL have port out_valid  out  1  buffered instruction valid.
REQ-011 SHALL have port out_instr  out  32 [0:31]  buffered instruction.
REQ-012 SHALL have port out_pc  out  32 [0:31]  {fetched pc+1, 2'b00}.
REQ-013 SHALL have port out_ready  in  1  downstream accepts instruction.
REQ-014 SHALL have port redir_valid  in  1  one-cycle redirect (taken branch, jump, JAL, jump register).
REQ-015 SHALL have port redir_target  in  30 [0:29]  redirect word address.
REQ-016 SHALL have port halt  in  1  level; suppress new fetches.

Function
REQ-017 SHALL implement states FETCH, WAIT, SQUASH, HALTED in one registered state machine; internal pc register PC_WIDTH bits; bit 0 is MSB on all buses.
REQ-018 SHALL drive imem_req=1 in FETCH and SQUASH only, 0 otherwise.
REQ-019 SHALL hold imem_addr constant while imem_req=1 until a rising edge with imem_req&&imem_ack (completion); ack may arrive in the first request cycle.
REQ-020 SHALL, in FETCH on completion without redirect: load out_instr<=imem_data, out_pc<={pc+1,00}, out_valid<=1, pc<=pc+1, go WAIT.
REQ-021 SHALL compute pc+1 modulo 2^PC_WIDTH (30'h3FFFFFFF wraps to 0).
REQ-022 SHALL, in WAIT, hold out_valid/out_instr/out_pc stable until out_ready=1; transfer on edge with out_valid&&out_ready clears out_valid, next state FETCH if halt=0, HALTED if halt=1.
REQ-023 SHALL give redir_valid priority over all other events in every state.
REQ-024 SHALL, on redirect in FETCH without completion: pc<=redir_target, go SQUASH, imem_addr keeps old address.
REQ-025 SHALL, on redirect coinciding with completion (FETCH or SQUASH): discard imem_data, out_valid stays 0, pc<=redir_target, go FETCH.
REQ-026 SHALL, in SQUASH: on completion discard data and go FETCH at pc; a further redirect overwrites pc, stays SQUASH unless completing.
REQ-027 SHALL, on redirect in WAIT: clear out_valid (instruction dropped, even if out_ready=1 same cycle), pc<=redir_target, go FETCH.
REQ-028 SHALL, in HALTED: imem_req=0; go FETCH when halt=0; redirect loads pc and goes FETCH regardless of halt.
REQ-029 SHALL never present a discarded instruction on out_valid.

Reset
REQ-030 SHALL on reset=0 immediately (asynchronously) set state FETCH, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0; imem_req=1 with imem_addr={RESET_PC,00} while in reset is permitted only after reset deasserts — imem_req SHALL be 0 while reset=0.
REQ-031 SHALL, on reset mid-transaction, abandon the outstanding request; an ack arriving during reset is ignored.

Verification
REQ-032 SHALL test: reset release, imem_ack=1, out_ready=1 -> imem_addr 0x0,0x4,0x8 on successive fetches; first out_pc=0x4.
REQ-033 SHALL test: imem_ack delayed 3 cycles -> imem_req and imem_addr 0x0 stable 4 cycles, exactly one out_valid capture.
REQ-034 SHALL test: pc=5 outstanding, redir_valid with target 30'h100, ack 2 cycles later -> pc-5 data never on out_valid; next imem_addr 0x400.
REQ-035 SHALL test: out_ready=0 for 5 cycles in WAIT -> out_valid/out_instr/out_pc stable, imem_req=0, pc unchanged.
REQ-036 SHALL test: pc=30'h3FFFFFFF fetched -> out_pc 0x00000000, next imem_addr 0x0.
REQ-037 SHALL test: halt=1 during WAIT, transfer -> HALTED, imem_req=0; redirect to 30'h20 -> imem_addr 0x80 next cycle.
